// File: rtl/summator_pkg.sv
// Shared definitions for the summator family: sequencer state encoding and the
// majority helper used to form the carry of a 1-bit full-adder cell.
package summator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell; the serial sequencer cycles one of these.
module full_adder_bit
    import summator_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = maj3(a_i, b_i, cin_i);

endmodule

// File: rtl/summator_serial_ctrl.sv
// Bit-serial adder sequencer: accepts A/B/Cin, adds one bit per clock LSB-first
// through a single full-adder cell, then holds {carry,sum} until the consumer takes it.
module summator_serial_ctrl
    import summator_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int serial_number = 0
) (
    input  logic                                      input_clk,
    input  logic                                      input_reset_n,
    input  logic                                      input_start_valid,
    output logic                                      output_start_ready,
    input  logic [WIDTH-1:0]                          input_operand_a,
    input  logic [WIDTH-1:0]                          input_operand_b,
    input  logic                                      input_carry_in,
    input  logic                                      input_abort,
    output logic                                      output_busy,
    output logic [(($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1)-1:0] output_bit_index,
    output logic [WIDTH-1:0]                          output_result,
    output logic                                      output_carry,
    output logic                                      output_result_valid,
    input  logic                                      input_result_ready
);

    localparam int CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 1) begin : g_width_chk
        $error("summator_serial_ctrl[%0d]: WIDTH must be >= 1", serial_number);
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic [WIDTH-1:0]   sh_r_q, sh_r_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Goes high on the first edge out of reset so start_ready stays low while in reset.
    logic               live_q;

    logic               fa_sum;
    logic               fa_cout;

    full_adder_bit u_fa (
        .a_i    (sh_a_q[0]),
        .b_i    (sh_b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    always_ff @(posedge input_clk or negedge input_reset_n) begin
        if (!input_reset_n) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_r_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_r_q  <= sh_r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_r_d  = sh_r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (live_q && input_start_valid) begin
                    sh_a_d  = input_operand_a;
                    sh_b_d  = input_operand_b;
                    sh_r_d  = '0;
                    carry_d = input_carry_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (input_abort) begin
                    sh_r_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    sh_a_d  = sh_a_q >> 1;
                    sh_b_d  = sh_b_q >> 1;
                    // Shift-then-insert keeps this legal for WIDTH=1.
                    sh_r_d  = sh_r_q >> 1;
                    sh_r_d[WIDTH-1] = fa_sum;
                    carry_d = fa_cout;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (input_abort) begin
                    sh_r_d  = '0;
                    carry_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (input_result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign output_start_ready  = live_q && (state_q == ST_IDLE);
    assign output_busy         = (state_q == ST_RUN);
    assign output_bit_index    = (state_q == ST_RUN) ? cnt_q : '0;
    assign output_result_valid = (state_q == ST_DONE);
    assign output_result       = (state_q == ST_DONE) ? sh_r_q : '0;
    assign output_carry        = (state_q == ST_DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_summator_serial_ctrl.sv
// Directed bench for the bit-serial adder sequencer at WIDTH=8.
module tb_summator_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a, op_b;
    logic         cin;
    logic         abort;
    logic         busy;
    logic [2:0]   bit_index;
    logic [W-1:0] result;
    logic         carry;
    logic         result_valid;
    logic         result_ready;

    int checks = 0;
    int errors = 0;

    summator_serial_ctrl #(.WIDTH(W), .serial_number(1)) dut (
        .input_clk           (clk),
        .input_reset_n       (rst_n),
        .input_start_valid   (start_valid),
        .output_start_ready  (start_ready),
        .input_operand_a     (op_a),
        .input_operand_b     (op_b),
        .input_carry_in      (cin),
        .input_abort         (abort),
        .output_busy         (busy),
        .output_bit_index    (bit_index),
        .output_result       (result),
        .output_carry        (carry),
        .output_result_valid (result_valid),
        .input_result_ready  (result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, measure latency, optionally stall, then consume the result.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int stall);
        logic [W:0] exp_sum;
        logic [W:0] held;
        int n;
        exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        n = 0;
        while (!start_ready && n < 20) begin step(); n++; end
        chk({tag, "_ready"}, start_ready, 1'b1);
        op_a = a; op_b = b; cin = c; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        op_a = ~a; op_b = ~b; cin = ~c;
        n = 0;
        while (!result_valid && n < 40) begin step(); n++; end
        chk({tag, "_latency"}, n, W);
        chk({tag, "_sum"}, {carry, result}, exp_sum);
        held = {carry, result};
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold"}, {start_ready, result_valid, carry, result}, {2'b01, held});
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk({tag, "_release"}, {result_valid, start_ready}, 2'b01);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        int           n;
        rst_n = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        abort = 1'b0; result_ready = 1'b0;
        #12;
        chk("reset_outs", {start_ready, busy, bit_index, result, carry, result_valid}, '0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", start_ready, 1'b0);
        step();
        chk("ready_after_edge", start_ready, 1'b1);

        // Basic and overflow sums
        do_op("t1", 8'h0F, 8'h01, 1'b0, 0);
        do_op("t2a", 8'hFF, 8'h01, 1'b0, 0);
        do_op("t2b", 8'hFF, 8'hFF, 1'b1, 0);
        do_op("t2c", 8'h00, 8'h00, 1'b1, 0);

        // Backpressure: 5 stalled cycles in DONE
        do_op("t3", 8'hA5, 8'h3C, 1'b1, 5);

        // Abort at bit_index 3
        op_a = 8'h77; op_b = 8'h11; cin = 1'b0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        chk("t4_busy", {busy, bit_index}, {1'b1, 3'd0});
        step(); step(); step();
        chk("t4_idx3", bit_index, 3'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_aborted", {busy, start_ready, result_valid}, 3'b010);
        n = 0;
        for (int i = 0; i < 12; i++) begin step(); if (result_valid) n++; end
        chk("t4_no_valid", n, 0);
        do_op("t4_after", 8'h12, 8'h34, 1'b0, 0);

        // Abort in DONE drops the result
        op_a = 8'h01; op_b = 8'h02; cin = 1'b0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (W) step();
        chk("t4d_valid", result_valid, 1'b1);
        abort = 1'b1; result_ready = 1'b0;
        step();
        abort = 1'b0;
        chk("t4d_dropped", {result_valid, start_ready, result, carry}, {2'b01, {W{1'b0}}, 1'b0});

        // start_valid held high through RUN with changing operands: no reload
        op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; start_valid = 1'b1;
        step();
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b1;
        repeat (W) step();
        chk("t5_noreload", {result_valid, carry, result}, {2'b10, 8'h10});
        step();
        chk("t5_held", {result_valid, start_ready, result}, {2'b10, 8'h10});
        start_valid = 1'b0; result_ready = 1'b1;
        step();
        result_ready = 1'b0;

        // Async reset mid-RUN
        op_a = 8'hC3; op_b = 8'h3C; cin = 1'b1; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step(); step();
        chk("t5_inrun", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_rst", {start_ready, busy, bit_index, result, carry, result_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t5_post_rst_ready", {start_ready, busy}, 2'b10);

        // Pseudo-random directed sweep with varying stalls
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op("sweep", ra, rb, rc, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
